// File: rtl/hazard_pkg.sv
// Shared types and helpers for the MIPS hazard/sequencing controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    EXEC = 2'b10
  } mul_state_e;

  localparam int MUL_CNT_W = 4;

  // Memory-stage result is younger than Writeback, so it wins when both match.
  function automatic fwd_sel_e fwd_select(
    input logic       regwrite_m,
    input logic [4:0] writereg_m,
    input logic       regwrite_w,
    input logic [4:0] writereg_w,
    input logic [4:0] src
  );
    if (regwrite_m && (writereg_m != 5'd0) && (writereg_m == src))
      return FWD_MEM;
    else if (regwrite_w && (writereg_w != 5'd0) && (writereg_w == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side signals of the hazard controller: register tags in, stall/flush/forward controls out.
interface hazard_if
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic [4:0]       rsD, rtD;
  logic             muladdD;
  logic [4:0]       rsE, rtE;
  logic [4:0]       writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW;
  logic             memtoregE;
  logic             pcsrcM;
  logic             stallF, stallD;
  logic             flushD, flushE;
  fwd_sel_e         fwdAE, fwdBE;
  logic             stall_state;
  logic             stallDMUL;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rsD, rtD, muladdD, rsE, rtE,
    output writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoregE, pcsrcM,
    input  stallF, stallD, flushD, flushE, fwdAE, fwdBE,
    input  stall_state, stallDMUL, mul_busy, stall_cycles
  );

  modport slave (
    input  rsD, rtD, muladdD, rsE, rtE,
    input  writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoregE, pcsrcM,
    output stallF, stallD, flushD, flushE, fwdAE, fwdBE,
    output stall_state, stallDMUL, mul_busy, stall_cycles
  );

endinterface

// File: rtl/mul_seq.sv
// MULADD sequencer: one accumulator-read cycle followed by execute cycles,
// holding the front end for MUL_CYCLES cycles in total.
module mul_seq
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_abort,
  output logic o_stall_state,
  output logic o_stall_dmul,
  output logic o_busy
);

  localparam logic [MUL_CNT_W-1:0] CNT_INIT = MUL_CNT_W'(MUL_CYCLES - 1);

  mul_state_e           r_state;
  logic [MUL_CNT_W-1:0] r_cnt;
  logic                 r_stall_state;
  logic                 r_stall_dmul;
  logic                 r_busy;

  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_stall_state <= 1'b0;
      r_stall_dmul  <= 1'b0;
      r_busy        <= 1'b0;
    end else if (i_abort) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_stall_state <= 1'b0;
      r_stall_dmul  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state       <= ACC;
            r_stall_state <= 1'b1;
            r_stall_dmul  <= 1'b1;
            r_busy        <= 1'b1;
          end else begin
            r_stall_state <= 1'b0;
            r_stall_dmul  <= 1'b0;
            r_busy        <= 1'b0;
          end
        end
        ACC: begin
          r_state       <= EXEC;
          r_cnt         <= CNT_INIT;
          r_stall_state <= 1'b0;
          r_stall_dmul  <= (CNT_INIT != '0);
          r_busy        <= 1'b1;
        end
        EXEC: begin
          r_stall_state <= 1'b0;
          if (r_cnt != '0) begin
            r_cnt        <= r_cnt - MUL_CNT_W'(1);
            r_stall_dmul <= (r_cnt != MUL_CNT_W'(1));
            r_busy       <= 1'b1;
          end else begin
            r_state      <= IDLE;
            r_stall_dmul <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_cnt         <= '0;
          r_stall_state <= 1'b0;
          r_stall_dmul  <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign o_stall_state = r_stall_state;
  assign o_stall_dmul  = r_stall_dmul;
  assign o_busy        = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, branch flush,
// MULADD sequencing and a stall-cycle counter for the performance monitor.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);

  logic             w_lwstall;
  logic             w_start;
  logic             w_stall;
  logic             w_stall_state;
  logic             w_stall_dmul;
  logic             w_busy;
  logic [CNT_W-1:0] r_stall_cycles;

  assign hz.fwdAE = fwd_select(hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW, hz.rsE);
  assign hz.fwdBE = fwd_select(hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW, hz.rtE);

  assign w_lwstall = hz.memtoregE & hz.regwriteE & (hz.writeregE != 5'd0) &
                     ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD));

  // A taken branch squashes the MULADD and must let the redirected PC load.
  assign w_start = hz.muladdD & ~w_lwstall & ~hz.pcsrcM;
  assign w_stall = (w_lwstall | w_stall_dmul) & ~hz.pcsrcM;

  mul_seq #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_seq (
    .clk           (clk),
    .reset         (reset),
    .i_start       (w_start),
    .i_abort       (hz.pcsrcM),
    .o_stall_state (w_stall_state),
    .o_stall_dmul  (w_stall_dmul),
    .o_busy        (w_busy)
  );

  assign hz.stallF      = w_stall;
  assign hz.stallD      = w_stall;
  assign hz.flushD      = hz.pcsrcM;
  assign hz.flushE      = w_lwstall | hz.pcsrcM;
  assign hz.stall_state = w_stall_state;
  assign hz.stallDMUL   = w_stall_dmul;
  assign hz.mul_busy    = w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall_cycles <= '0;
    else if (w_stall)
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
  end

  assign hz.stall_cycles = r_stall_cycles;

endmodule
